// File: rtl/sfq_capture_pkg.sv
// ----------------------------------------------------------------------------
// sfq_capture_pkg
// Shared defaults and types for the SFQ pulse capture block.
//   TS_W_DEFAULT    : timestamp / counter width
//   DEPTH_DEFAULT   : event FIFO entries (power of two, >= 2)
//   MIN_GAP_DEFAULT : minimum legal clk cycles between consecutive pulses
//   gap_state_t     : minimum-gap checker states (used only when the
//                     SFQ_CAPTURE_GAP_CHECK_EN build macro is defined)
// ----------------------------------------------------------------------------
package sfq_capture_pkg;

    localparam int unsigned TS_W_DEFAULT    = 16;
    localparam int unsigned DEPTH_DEFAULT   = 4;
    localparam int unsigned MIN_GAP_DEFAULT = 2;

    typedef enum logic {
        GAP_FIRST = 1'b0,   // no pulse seen since reset or clr
        GAP_TRACK = 1'b1    // measuring distance to the previous pulse
    } gap_state_t;

endpackage : sfq_capture_pkg

// File: rtl/sfq_event_fifo.sv
// ----------------------------------------------------------------------------
// sfq_event_fifo
// Small synchronous FIFO for captured pulse timestamps.
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push         : write request for push_data
//   push_data[W] : entry to store
//   pop_ready    : consumer takes the head entry when pop_valid is high
//   pop_valid    : FIFO non-empty
//   pop_data[W]  : head entry, 0 when empty
//   full         : all DEPTH entries occupied
//   drop         : push refused because full and no pop this cycle
// A push while full is still accepted when a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module sfq_event_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         pop_valid,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         pop;
    logic         accept;

    assign pop_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = pop_valid && pop_ready;
    assign accept    = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign pop_data  = pop_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries
    // are live, so clearing the array would only cost reset routing.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule : sfq_event_fifo

// File: rtl/sfq_pulse_capture.sv
// ----------------------------------------------------------------------------
// sfq_pulse_capture
// Timestamps pulses on a toggle-encoded SFQ line and queues them for a
// consumer, with saturating pulse/drop counters and sticky status flags.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in               : toggle-encoded SFQ line (asynchronous); each level
//                      change is one pulse
//   clr              : synchronous clear of counters, flags and gap checker
//   ev_valid/ev_ready: event FIFO head handshake
//   ev_ts[TS_W]      : head timestamp, 0 when empty
//   pulse_cnt[TS_W]  : saturating count of detected pulses
//   drop_cnt[TS_W]   : saturating count of pulses lost to a full FIFO
//   overflow         : sticky, set on any drop
//   gap_viol         : sticky minimum-gap violation
// Build option: define SFQ_CAPTURE_GAP_CHECK_EN to compile in the minimum-gap
// checker; without it gap_viol is tied to 0.
// ----------------------------------------------------------------------------
module sfq_pulse_capture
    import sfq_capture_pkg::*;
#(
    parameter int unsigned TS_W    = TS_W_DEFAULT,
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned MIN_GAP = MIN_GAP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in,
    input  logic            clr,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [TS_W-1:0] ev_ts,
    output logic [TS_W-1:0] pulse_cnt,
    output logic [TS_W-1:0] drop_cnt,
    output logic            overflow,
    output logic            gap_viol
);

    logic            s1, s2, s3;
    logic            pulse;
    logic [TS_W-1:0] ts;
    logic            drop;
    // The FIFO reports full for other users; this block only needs drop.
    logic            fifo_full_unused;

    // NOTE: non-blocking assignments make each stage take the previous
    // stage's old value, giving a real two-flop synchronizer plus history.
    // s3 resets to 0 because the line idles low, so a line already high at
    // reset release is seen as one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 ^ s3;

    // Free-running timestamp; a push captures the value before this edge's
    // increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + 1'b1;
    end

    sfq_event_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pulse),
        .push_data (ts),
        .pop_ready (ev_ready),
        .pop_valid (ev_valid),
        .pop_data  (ev_ts),
        .full      (fifo_full_unused),
        .drop      (drop)
    );

    // clr has priority over a coincident pulse here; the FIFO still takes
    // that pulse because its push path does not look at clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            pulse_cnt <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pulse && (pulse_cnt != '1)) pulse_cnt <= pulse_cnt + 1'b1;
            if (drop  && (drop_cnt  != '1)) drop_cnt  <= drop_cnt + 1'b1;
            if (drop)                       overflow  <= 1'b1;
        end
    end

`ifdef SFQ_CAPTURE_GAP_CHECK_EN
    localparam int unsigned     GAP_W   = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(MIN_GAP);

    gap_state_t       gap_state;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_viol_q;

    // gap_cnt counts edges since the previous pulse; a pulse arriving with
    // gap_cnt + 1 < MIN_GAP is closer than allowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_state  <= GAP_FIRST;
            gap_cnt    <= '0;
            gap_viol_q <= 1'b0;
        end else if (clr) begin
            gap_state  <= GAP_FIRST;
            gap_cnt    <= '0;
            gap_viol_q <= 1'b0;
        end else begin
            case (gap_state)
                GAP_FIRST: begin
                    if (pulse) begin
                        gap_state <= GAP_TRACK;
                        gap_cnt   <= '0;
                    end
                end
                GAP_TRACK: begin
                    if (pulse) begin
                        if ((int'(gap_cnt) + 1) < int'(MIN_GAP)) gap_viol_q <= 1'b1;
                        gap_cnt <= '0;
                    end else if (gap_cnt != GAP_SAT) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign gap_viol = gap_viol_q;
`else
    assign gap_viol = 1'b0;
`endif

endmodule : sfq_pulse_capture

// File: tb/tb_sfq_pulse_capture.sv
// ----------------------------------------------------------------------------
// tb_sfq_pulse_capture
// Self-checking bench for sfq_pulse_capture: a cycle model feeds a timestamp
// scoreboard compared every cycle, a vector table drives the FIFO-fill
// sequence, and hand-written sequences cover the multi-cycle corners.
// A second instance with TS_W=4 covers timestamp wrap.
// ----------------------------------------------------------------------------
module tb_sfq_pulse_capture;

`ifdef SFQ_CAPTURE_GAP_CHECK_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in = 1'b0;
    logic        clr = 1'b0;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic [15:0] ev_ts, pulse_cnt, drop_cnt;
    logic        overflow, gap_viol;

    logic        in4 = 1'b0;
    logic        clr4 = 1'b0;
    logic        ev_ready4 = 1'b0;
    logic        ev_valid4;
    logic [3:0]  ev_ts4, pulse_cnt4, drop_cnt4;
    logic        overflow4, gap_viol4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sfq_pulse_capture dut (
        .clk(clk), .rst_n(rst_n), .in(in), .clr(clr),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ts(ev_ts),
        .pulse_cnt(pulse_cnt), .drop_cnt(drop_cnt),
        .overflow(overflow), .gap_viol(gap_viol)
    );

    sfq_pulse_capture #(.TS_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in(in4), .clr(clr4),
        .ev_valid(ev_valid4), .ev_ready(ev_ready4), .ev_ts(ev_ts4),
        .pulse_cnt(pulse_cnt4), .drop_cnt(drop_cnt4),
        .overflow(overflow4), .gap_viol(gap_viol4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard (main instance) ----------
    logic        m1, m2, m3;
    logic [15:0] mts, m_pc, m_dc;
    logic        m_ovf;
    logic [3:0]  mts4;
    logic [15:0] sb_q[$];
    bit          mon_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= 1'b0; m2 <= 1'b0; m3 <= 1'b0;
            mts <= '0; m_pc <= '0; m_dc <= '0; m_ovf <= 1'b0;
            mts4 <= '0;
            sb_q.delete();
        end else begin
            automatic logic p   = m2 ^ m3;
            automatic logic pop = (sb_q.size() != 0) && ev_ready;
            automatic logic drp = p && (sb_q.size() == 4) && !pop;
            if (pop) void'(sb_q.pop_front());
            if (p && !drp) sb_q.push_back(mts);
            if (clr) begin
                m_pc <= '0; m_dc <= '0; m_ovf <= 1'b0;
            end else begin
                if (p && m_pc != 16'hFFFF)   m_pc <= m_pc + 1'b1;
                if (drp && m_dc != 16'hFFFF) m_dc <= m_dc + 1'b1;
                if (drp)                     m_ovf <= 1'b1;
            end
            m1 <= in; m2 <= m1; m3 <= m2;
            mts  <= mts + 1'b1;
            mts4 <= mts4 + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("sb_ev_valid", ev_valid, sb_q.size() != 0);
            check("sb_ev_ts", ev_ts, (sb_q.size() != 0) ? sb_q[0] : 16'd0);
            check("sb_pulse_cnt", pulse_cnt, m_pc);
            check("sb_drop_cnt", drop_cnt, m_dc);
            check("sb_overflow", overflow, m_ovf);
        end
    end

    // ---------------- FIFO fill vector table ---------------------------------
    typedef struct {
        bit          toggle;
        bit          ready;
        bit          clr;
        int          cycles;
        logic [15:0] exp_pulse;
        logic [15:0] exp_drop;
        bit          exp_ovf;
        bit          exp_valid;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int  n;
        bit  found;

        vecs[0] = '{toggle: 1'b0, ready: 1'b1, clr: 1'b1, cycles: 3,
                    exp_pulse: 16'd0, exp_drop: 16'd0, exp_ovf: 1'b0, exp_valid: 1'b0};
        for (int i = 1; i <= 6; i++) begin
            vecs[i] = '{toggle: 1'b1, ready: 1'b0, clr: 1'b0, cycles: 4,
                        exp_pulse: 16'(i), exp_drop: (i > 4) ? 16'(i - 4) : 16'd0,
                        exp_ovf: (i > 4), exp_valid: 1'b1};
        end

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_ts", ev_ts, 0);
        check("rst_pulse_cnt", pulse_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_gap_viol", gap_viol, 0);
        check("rst_ev_valid4", ev_valid4, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // ---- first pulse latency: toggle before edge 10 -> entry ts 12 ----
        repeat (10) @(posedge clk);
        @(negedge clk);
        in = 1'b1;
        repeat (2) @(negedge clk);
        check("lat_valid_early", ev_valid, 0);
        @(negedge clk);
        check("lat_valid", ev_valid, 1);
        check("lat_ts", ev_ts, 16'd12);
        check("lat_pulse_cnt", pulse_cnt, 16'd1);

        // ---- timestamp wrap on the TS_W=4 instance ----
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mts4 == 4'd13) begin
                found = 1'b1;
                break;
            end
        end
        check("wrap_sync_found", found, 1);
        in4 = ~in4;
        repeat (2) @(negedge clk);
        in4 = ~in4;
        repeat (4) @(negedge clk);
        check("wrap_valid", ev_valid4, 1);
        check("wrap_ts_first", ev_ts4, 4'd15);
        check("wrap_pulse_cnt", pulse_cnt4, 4'd2);
        ev_ready4 = 1'b1;
        @(negedge clk);
        ev_ready4 = 1'b0;
        check("wrap_ts_second", ev_ts4, 4'd1);
        ev_ready4 = 1'b1;
        @(negedge clk);
        ev_ready4 = 1'b0;
        check("wrap_empty", ev_valid4, 0);
        check("wrap_drop", drop_cnt4, 0);
        check("wrap_ovf", overflow4, 0);
        check("wrap_gap", gap_viol4, 0);

        // ---- fill past full with the consumer stalled ----
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].toggle) in = ~in;
            ev_ready = vecs[v].ready;
            clr      = vecs[v].clr;
            @(negedge clk);
            clr = 1'b0;
            repeat (vecs[v].cycles - 1) @(negedge clk);
            check($sformatf("vec%0d_pulse_cnt", v), pulse_cnt, vecs[v].exp_pulse);
            check($sformatf("vec%0d_drop_cnt", v), drop_cnt, vecs[v].exp_drop);
            check($sformatf("vec%0d_overflow", v), overflow, vecs[v].exp_ovf);
            check($sformatf("vec%0d_ev_valid", v), ev_valid, vecs[v].exp_valid);
        end

        // ---- full FIFO, pop coincides with push: no drop ----
        in = ~in;
        repeat (2) @(negedge clk);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        check("fullpop_drop_cnt", drop_cnt, 16'd2);
        check("fullpop_pulse_cnt", pulse_cnt, 16'd7);
        check("fullpop_valid", ev_valid, 1);
        ev_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (!ev_valid) break;
            @(negedge clk);
            n++;
        end
        check("fullpop_occupancy", n, 4);

        // ---- minimum gap: pulses one cycle apart ----
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        in = ~in;
        @(negedge clk);
        in = ~in;
        repeat (5) @(negedge clk);
        check("gap_close_viol", gap_viol, GAP_EN);
        check("gap_close_pulse_cnt", pulse_cnt, 16'd2);

        // ---- clr clears the flag; pulses three cycles apart stay legal ----
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("gap_clr_viol", gap_viol, 0);
        for (int k = 0; k < 3; k++) begin
            in = ~in;
            repeat (3) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("gap_wide_viol", gap_viol, 0);
        check("gap_wide_pulse_cnt", pulse_cnt, 16'd3);

        // ---- clr together with a pulse; next pulse is first after clr ----
        in = ~in;
        @(negedge clk);
        in = ~in;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("clrpulse_pulse_cnt", pulse_cnt, 16'd1);
        check("clrpulse_viol", gap_viol, 0);
        repeat (4) @(negedge clk);

        // ---- reset mid-operation with entries queued ----
        ev_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in = ~in;
            repeat (4) @(negedge clk);
        end
        check("midrst_pre_valid", ev_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", ev_valid, 0);
        check("midrst_ev_ts", ev_ts, 0);
        check("midrst_pulse_cnt", pulse_cnt, 0);
        in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rel_pulse_cnt", pulse_cnt, 16'd1);
        check("rel_valid", ev_valid, 1);
        check("rel_ev_ts", ev_ts, 16'd2);
        ev_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_drained", ev_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sfq_pulse_capture
